// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to the tx and rx paths),
// default frame constants and the idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;
  localparam int unsigned WORD_SIZE_DEF    = 8;
  localparam logic        LINE_IDLE        = 1'b1;

endpackage

// File: rtl/uart_parity_checker.sv
// Odd-parity generator/checker shared by the UART paths: the bit is 1 when
// the word holds an even number of ones.
module parity_checker #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic [WORD_SIZE-1:0] data_i,
  output logic                 parity_o_c
);

  assign parity_o_c = ~(^data_i);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, LSB-first serialisation with
// optional odd parity and one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_SIZE - 1);
  localparam logic              STOP_LAST = (STOP_BITS > 1);

  uart_state_e          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic parity_c;
  logic accept_c;
  logic baud_tc_c;

  parity_checker #(.WORD_SIZE(WORD_SIZE)) u_parity (
    .data_i     (i_data),
    .parity_o_c (parity_c)
  );

  assign accept_c  = i_valid && ready_q;
  assign baud_tc_c = (baud_q == BAUD_LAST);

  // Next-state logic; the state register always names the bit currently on the line.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    par_d   = par_q;

    if (state_q != ST_IDLE) begin
      baud_d = baud_tc_c ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_START;
          baud_d  = '0;
          data_d  = i_data;
          par_d   = parity_c;
        end
      end
      ST_START: begin
        if (baud_tc_c) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tc_c) begin
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tc_c) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (baud_tc_c) begin
          if (stop_q == STOP_LAST) begin
            if (accept_c) begin
              state_d = ST_START;
              data_d  = i_data;
              par_d   = parity_c;
            end else begin
              state_d = ST_IDLE;
            end
            stop_d = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    tx_d    = LINE_IDLE;
    done_d  = (state_q == ST_STOP) && (stop_q == STOP_LAST) && (baud_q == BAUD_PRE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) || done_d;

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_d];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: dut_a has parity and one stop bit, dut_b has no
// parity and two stop bits; both run at four clocks per bit.
module tb_uart_tx;

  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int vectors;
  int miscompares;

  uart_tx #(.CLKS_PER_BIT(4), .WORD_SIZE(8), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(4), .WORD_SIZE(8), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frames are written line-order from bit 0: start, d0..d7, parity/stop, stop.
  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {tx,busy,ready,done}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs(input logic sel);
    return sel ? {tx_b, busy_b, ready_b, done_b} : {tx_a, busy_a, ready_a, done_a};
  endfunction

  task automatic drive(input logic sel, input logic v, input logic [7:0] d);
    if (sel) begin valid_b = v; data_b = d; end
    else     begin valid_a = v; data_a = d; end
  endtask

  // Word presented now is accepted on the coming edge; returns in cycle 1.
  task automatic send(input logic sel, input logic [7:0] d);
    drive(sel, 1'b1, d);
    @(negedge clk);
  endtask

  // Checks 44 frame cycles; cycle 1 applies hold_valid/hold_data, and a 0xFF
  // pulse is injected on glitch_k (0 = none).
  task automatic run_frame(input logic sel, input string name, input logic [10:0] fr,
                           input logic hold_valid, input logic [7:0] hold_data,
                           input int glitch_k);
    logic [3:0] exp;
    for (int k = 1; k <= 44; k++) begin
      exp = {fr[(k - 1) / 4], 1'b1, (k == 44), (k == 44)};
      chk($sformatf("%s cyc%0d", name, k), outs(sel), exp);
      if (k == 1 || k == glitch_k + 1) drive(sel, hold_valid, hold_data);
      if (k == glitch_k) drive(sel, 1'b1, 8'hFF);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input logic sel, input string name, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s idle%0d", name, k), outs(sel), 4'b1010);
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    vecs[0] = '{1'b0, 8'h55, 11'b1_1_01010101_0};
    vecs[1] = '{1'b0, 8'h07, 11'b1_0_00000111_0};
    vecs[2] = '{1'b0, 8'h00, 11'b1_1_00000000_0};
    vecs[3] = '{1'b0, 8'h80, 11'b1_0_10000000_0};
    vecs[4] = '{1'b0, 8'hFE, 11'b1_0_11111110_0};
    vecs[5] = '{1'b1, 8'hFF, 11'b1_1_11111111_0};
    vecs[6] = '{1'b1, 8'h2C, 11'b1_1_00101100_0};

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset a", outs(1'b0), 4'b1010);
    chk("reset b", outs(1'b1), 4'b1010);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_idle(1'b0, "post-reset a", 2);

    // Single frames; i_data is scrambled after acceptance to show it is latched.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel, vecs[i].data);
      run_frame(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].frame, 1'b0, ~vecs[i].data, 0);
      check_idle(vecs[i].sel, $sformatf("vec%0d", i), 3);
    end

    // Back-to-back: 0xA5 then 0x3C with i_valid held through the first o_done.
    send(1'b0, 8'hA5);
    run_frame(1'b0, "b2b first", 11'b1_1_10100101_0, 1'b1, 8'h3C, 0);
    run_frame(1'b0, "b2b second", 11'b1_1_00111100_0, 1'b0, 8'h00, 0);
    check_idle(1'b0, "b2b", 3);

    // i_valid pulse while busy is ignored; no second frame follows.
    send(1'b0, 8'h55);
    run_frame(1'b0, "ignored valid", 11'b1_1_01010101_0, 1'b0, 8'h00, 10);
    check_idle(1'b0, "ignored valid", 50);

    // Reset on cycle 17 of an 0x81 frame drops it with no o_done.
    send(1'b0, 8'h81);
    drive(1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("pre-reset cyc%0d", k), outs(1'b0),
          {(k <= 4) ? 1'b0 : ((k <= 8) ? 1'b1 : 1'b0), 1'b1, 1'b0, 1'b0});
      if (k == 17) rst_a = 1'b1;
      @(negedge clk);
    end
    rst_a = 1'b0;
    check_idle(1'b0, "mid-frame reset", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
